// File: rtl/t48_bus_mux_sync_if.sv
// Bus bundle for t48_bus_mux_sync: per-source data/drive flags in, registered bus value and status out.
interface t48_bus_mux_sync_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 9
);
    logic                   en_clk_i;
    logic                   mode_i;
    logic [NSRC*WIDTH-1:0]  src_data_i;
    logic [NSRC-1:0]        src_drive_i;
    logic                   clr_err_i;
    logic [WIDTH-1:0]       data_o;
    logic                   valid_o;
    logic                   contention_o;
    logic [7:0]             err_cnt_o;

    modport master (
        output en_clk_i, mode_i, src_data_i, src_drive_i, clr_err_i,
        input  data_o, valid_o, contention_o, err_cnt_o
    );

    modport slave (
        input  en_clk_i, mode_i, src_data_i, src_drive_i, clr_err_i,
        output data_o, valid_o, contention_o, err_cnt_o
    );
endinterface

// File: rtl/t48_bus_mux_sync.sv
// Multi-source bus combiner (wired-AND or lowest-index priority select) with keeper and contention counter.
// Latency: one enabled clock, all outputs registered. Backpressure: none; en_clk_i freezes every register.
module t48_bus_mux_sync #(
    parameter int WIDTH   = 8,
    parameter int NSRC    = 9,
    parameter bit HOLD_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 res_i,
    t48_bus_mux_sync_if.slave    bus
);
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic             cont_q,  cont_d;
    logic [7:0]       cnt_q,   cnt_d;

    logic [WIDTH-1:0] and_dat;
    logic [WIDTH-1:0] sel_dat;
    logic             any_drv;
    logic             multi_drv;

    // Single pass over sources: AND of drivers, first driver found, and driver-count flags.
    always_comb begin
        and_dat   = '1;
        sel_dat   = '1;
        any_drv   = 1'b0;
        multi_drv = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.src_drive_i[k]) begin
                and_dat = and_dat & bus.src_data_i[k*WIDTH +: WIDTH];
                if (!any_drv) begin
                    sel_dat = bus.src_data_i[k*WIDTH +: WIDTH];
                end else begin
                    multi_drv = 1'b1;
                end
                any_drv = 1'b1;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = any_drv;
        cont_d  = bus.mode_i & multi_drv;
        cnt_d   = cnt_q;

        if (!any_drv) begin
            data_d = HOLD_EN ? data_q : '1;
        end else if (bus.mode_i) begin
            data_d = sel_dat;
        end else begin
            data_d = and_dat;
        end

        // Clear takes precedence over a same-edge contention increment.
        if (bus.clr_err_i) begin
            cnt_d = 8'd0;
        end else if (cont_d && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge res_i) begin
        if (!res_i) begin
            data_q  <= '1;
            valid_q <= 1'b0;
            cont_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else if (bus.en_clk_i) begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.valid_o      = valid_q;
    assign bus.contention_o = cont_q;
    assign bus.err_cnt_o    = cnt_q;
endmodule

// File: tb/tb_t48_bus_mux_sync.sv
// Bench for t48_bus_mux_sync: HOLD_EN=1 and HOLD_EN=0 instances share stimulus, checked against a reference model.
module tb_t48_bus_mux_sync;
    localparam int WIDTH = 8;
    localparam int NSRC  = 9;

    logic clk_i = 1'b0;
    logic res_n;
    always #5 clk_i = ~clk_i;

    logic             en, mode, clr;
    logic [NSRC-1:0]  drv;
    logic [WIDTH-1:0] src [NSRC];
    logic [NSRC*WIDTH-1:0] src_vec;

    always_comb begin
        src_vec = '0;
        for (int k = 0; k < NSRC; k++) src_vec[k*WIDTH +: WIDTH] = src[k];
    end

    t48_bus_mux_sync_if #(.WIDTH(WIDTH), .NSRC(NSRC)) b1 ();
    t48_bus_mux_sync_if #(.WIDTH(WIDTH), .NSRC(NSRC)) b0 ();

    assign b1.en_clk_i = en;   assign b0.en_clk_i = en;
    assign b1.mode_i = mode;   assign b0.mode_i = mode;
    assign b1.clr_err_i = clr; assign b0.clr_err_i = clr;
    assign b1.src_drive_i = drv; assign b0.src_drive_i = drv;
    assign b1.src_data_i = src_vec; assign b0.src_data_i = src_vec;

    t48_bus_mux_sync #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_EN(1'b1)) dut_hold (
        .clk_i(clk_i), .res_i(res_n), .bus(b1.slave));
    t48_bus_mux_sync #(.WIDTH(WIDTH), .NSRC(NSRC), .HOLD_EN(1'b0)) dut_float (
        .clk_i(clk_i), .res_i(res_n), .bus(b0.slave));

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_d1, exp_d0, exp_cnt;
    logic       exp_vld, exp_cont;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_d1 = 8'hFF; exp_d0 = 8'hFF; exp_vld = 1'b0; exp_cont = 1'b0; exp_cnt = 8'd0;
    endtask

    // Reference: count drivers, AND them or take the lowest index, per-instance keeper rule.
    task automatic model_edge();
        int nd;
        int first;
        logic [7:0] d;
        nd = $countones(drv);
        first = -1;
        d = 8'hFF;
        for (int k = 0; k < NSRC; k++) begin
            if (drv[k]) begin
                d = d & src[k];
                if (first < 0) first = k;
            end
        end
        if (nd == 0) begin
            exp_d0 = 8'hFF;
            exp_vld = 1'b0;
            exp_cont = 1'b0;
        end else begin
            if (mode) d = src[first];
            exp_d1 = d;
            exp_d0 = d;
            exp_vld = 1'b1;
            exp_cont = mode && (nd > 1);
        end
        if (clr) exp_cnt = 8'd0;
        else if (exp_cont && exp_cnt < 8'd255) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".data_hold"},  b1.data_o,       exp_d1);
        check_eq({tag, ".data_float"}, b0.data_o,       exp_d0);
        check_eq({tag, ".valid"},      b1.valid_o,      exp_vld);
        check_eq({tag, ".valid_f"},    b0.valid_o,      exp_vld);
        check_eq({tag, ".cont"},       b1.contention_o, exp_cont);
        check_eq({tag, ".cont_f"},     b0.contention_o, exp_cont);
        check_eq({tag, ".cnt"},        b1.err_cnt_o,    exp_cnt);
        check_eq({tag, ".cnt_f"},      b0.err_cnt_o,    exp_cnt);
    endtask

    task automatic step(input string tag);
        @(posedge clk_i);
        if (res_n && en) model_edge();
        @(negedge clk_i);
        check_all(tag);
    endtask

    task automatic clear_srcs();
        for (int k = 0; k < NSRC; k++) src[k] = 8'h00;
        drv = '0;
    endtask

    initial begin
        res_n = 1'b1;
        en = 1'b1; mode = 1'b0; clr = 1'b0;
        clear_srcs();
        model_reset();
        #2 res_n = 1'b0;
        #2 check_all("reset_async");
        repeat (2) @(negedge clk_i);
        res_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step("idle_after_reset");
            check_eq("idle_data", b1.data_o, 32'hFF);
        end

        src[0] = 8'hF3; src[4] = 8'h3F; drv = 9'b0_0001_0001; mode = 1'b0;
        step("wired_and");
        check_eq("wired_and_const", b1.data_o, 32'h33);

        clear_srcs();
        src[2] = 8'hA5; src[5] = 8'h5A; drv = 9'b0_0010_0100; mode = 1'b1;
        step("prio_contention");
        check_eq("prio_const", b1.data_o, 32'hA5);
        check_eq("prio_cnt_const", b1.err_cnt_o, 32'd1);

        clear_srcs();
        src[1] = 8'h12; drv = 9'b0_0000_0010;
        step("single_drv");
        check_eq("pulse_one_cycle", b1.contention_o, 32'd0);
        drv = '0;
        step("keeper");
        check_eq("keeper_hold", b1.data_o, 32'h12);
        check_eq("keeper_float", b0.data_o, 32'hFF);

        for (int i = 0; i < 400; i++) begin
            int sel;
            mode = 1'($urandom);
            for (int k = 0; k < NSRC; k++) src[k] = 8'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0) drv = '0;
            else if (sel == 1) drv = 9'(1) << $urandom_range(0, NSRC-1);
            else drv = 9'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step("random");
        end

        en = 1'b1; clr = 1'b0; mode = 1'b1;
        clear_srcs();
        src[2] = 8'hA5; src[5] = 8'h5A; drv = 9'b0_0010_0100;
        for (int i = 0; i < 300; i++) step("saturate");
        check_eq("sat_const", b1.err_cnt_o, 32'd255);
        clr = 1'b1;
        step("clr_wins");
        check_eq("clr_cnt_const", b1.err_cnt_o, 32'd0);
        check_eq("clr_cont_const", b1.contention_o, 32'd1);

        clr = 1'b0; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode = 1'($urandom);
            drv = 9'($urandom);
            for (int k = 0; k < NSRC; k++) src[k] = 8'($urandom);
            step("frozen");
        end
        check_eq("frozen_pulse", b1.contention_o, 32'd1);

        @(posedge clk_i);
        #2 res_n = 1'b0;
        model_reset();
        #1 check_all("reset_mid");
        @(negedge clk_i);
        res_n = 1'b1;
        en = 1'b1; mode = 1'b0;
        clear_srcs();
        src[3] = 8'h6C; drv = 9'b0_0000_1000;
        step("post_reset_live");
        check_eq("post_reset_const", b1.data_o, 32'h6C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/t48_bus_mux_sync.md
T48_BUS_MUX_SYNC -- requirements
Module: t48_bus_mux_sync

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bus data width; legal range 1..32.
REQ-002 Parameter NSRC, default 9, SHALL set the number of bus sources; legal range 2..16.
REQ-003 Parameter HOLD_EN, default 1, SHALL enable bus-keeper hold when no source drives (0 = float to all ones).
REQ-004 clk_i  in  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-005 res_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 en_clk_i  in  1  SHALL be the clock enable; state updates only when 1.
REQ-007 mode_i  in  1  SHALL select combining mode: 0 = wired-AND, 1 = priority select.
REQ-008 src_data_i  in  NSRC*WIDTH  SHALL carry source data; source k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-009 src_drive_i  in  NSRC  SHALL flag that source k drives the bus this cycle.
REQ-010 clr_err_i  in  1  SHALL synchronously clear the contention counter (qualified by en_clk_i).
REQ-011 data_o  out  WIDTH  SHALL be the registered bus value.
REQ-012 valid_o  out  1  SHALL flag that data_o was loaded from at least one driving source.
REQ-013 contention_o  out  1  SHALL be a registered one-enabled-cycle contention pulse.
REQ-014 err_cnt_o  out  8  SHALL be the saturating contention event count.

Function
REQ-015 Latency SHALL be one enabled clock: inputs sampled at an edge with en_clk_i=1 appear on outputs after that edge.
REQ-016 With en_clk_i=0 all registers SHALL hold, including contention_o (pulse extends until next enabled edge).
REQ-017 Wired-AND mode: next data SHALL be the bitwise AND over k of (src_drive_i[k] ? source k data : all ones).
REQ-018 Wired-AND mode: multiple drivers SHALL be legal; contention_o next = 0.
REQ-019 Select mode, one driver: next data SHALL equal that source's data; contention_o next = 0.
REQ-020 Select mode, two or more drivers: next data SHALL equal the lowest-index driving source; contention_o next = 1.
REQ-021 No driver (either mode): next data SHALL be held data_o if HOLD_EN=1, else all ones; valid_o next = 0.
REQ-022 Any driver present: valid_o next SHALL be 1.
REQ-023 err_cnt_o SHALL increment by 1 on each enabled edge where REQ-020 contention is detected, saturating at 255.
REQ-024 clr_err_i=1 with contention on the same enabled edge: err_cnt_o SHALL become 0 (clear wins); contention_o still pulses.
REQ-025 mode_i change SHALL take effect at the next enabled edge with no extra state or bubble.
REQ-026 Block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-027 res_i=0 SHALL immediately force data_o = all ones, valid_o = 0, contention_o = 0, err_cnt_o = 0, independent of clk_i and en_clk_i.
REQ-028 Reset asserted mid-operation SHALL discard in-flight sampled data; first enabled edge after release uses live inputs.

Verification
REQ-029 Reset release, no drivers, HOLD_EN=1, 3 enabled edges -> data_o=0xFF, valid_o=0, err_cnt_o=0 throughout.
REQ-030 mode_i=0, src0=0xF3 and src4=0x3F driving, en_clk_i=1 -> next edge data_o=0x33, valid_o=1, contention_o=0.
REQ-031 mode_i=1, src2=0xA5 and src5=0x5A driving -> data_o=0xA5, contention_o=1 for one enabled cycle, err_cnt_o=1.
REQ-032 mode_i=1, src1=0x12 driving one edge, then no drivers: HOLD_EN=1 -> data_o stays 0x12, valid_o=0; HOLD_EN=0 -> data_o=0xFF.
REQ-033 300 consecutive contention edges -> err_cnt_o saturates at 255; then clr_err_i=1 with contention -> err_cnt_o=0, contention_o=1.
REQ-034 en_clk_i=0 while drivers toggle, then res_i low asynchronously mid-cycle -> outputs frozen while disabled, reset values immediately on res_i fall.
